// File: rtl/spi_word_controller.sv
// spi_word_controller: mode-0, MSB-first SPI initiator exchanging one WORD_BITS word per transaction.
// Define SPI_CONTROLLER_BURST_EN to add cs_hold, which keeps CS low across consecutive words.
module spi_word_controller #(
  parameter int WORD_BITS = 64,
  parameter int CLK_DIV   = 4,
  parameter int CS_SETUP  = 2,
  parameter int CS_IDLE   = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [WORD_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
`ifdef SPI_CONTROLLER_BURST_EN
  input  logic                 cs_hold,
`endif
  output logic [WORD_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 SCK,
  output logic                 CS,
  output logic                 COPI,
  input  logic                 CIPO,
  output logic [2:0]           dbg_state
);

  // Handshake: a word is accepted in the cycle where tx_valid && tx_ready are both high;
  // tx_data is captured then and never re-sampled. rx_valid is a one-cycle pulse with no backpressure.

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_TAIL  = 3'd4,
    ST_GAP   = 3'd5,
    ST_WAIT  = 3'd6
  } state_t;

  localparam int CNT_MAX0 = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int CNT_MAX  = (CNT_MAX0 > CS_IDLE) ? CNT_MAX0 : CS_IDLE;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int BIT_W    = $clog2(WORD_BITS + 1);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);
  localparam logic [BIT_W-1:0] BITS_ALL   = BIT_W'(WORD_BITS);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [BIT_W-1:0]       bit_next;
  logic [WORD_BITS-1:0]  tx_sr_q, tx_sr_d;
  logic [WORD_BITS-1:0]  rx_sr_q, rx_sr_d;
  logic [WORD_BITS-1:0]  rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   tx_ready_q, tx_ready_d;
  logic                   busy_q, busy_d;
  logic                   sck_q, sck_d;
  logic                   cs_q, cs_d;
  logic                   copi_q, copi_d;
  logic                   accept;
`ifdef SPI_CONTROLLER_BURST_EN
  logic                   hold_q, hold_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    bit_next   = bit_cnt_q + 1'b1;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_ready_d = tx_ready_q;
    busy_d     = busy_q;
    sck_d      = sck_q;
    cs_d       = cs_q;
    copi_d     = copi_q;
    accept     = tx_valid && tx_ready_q;
`ifdef SPI_CONTROLLER_BURST_EN
    hold_d     = hold_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tx_sr_d    = tx_data;
          copi_d     = tx_data[WORD_BITS-1];
          cs_d       = 1'b0;
          tx_ready_d = 1'b0;
          busy_d     = 1'b1;
          cnt_d      = '0;
          bit_cnt_d  = '0;
          state_d    = ST_SETUP;
`ifdef SPI_CONTROLLER_BURST_EN
          hold_d     = cs_hold;
`endif
        end
      end

      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          sck_d   = 1'b1;
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_HIGH: begin
        if (cnt_q == DIV_LAST) begin
          // Sample CIPO on the cycle SCK falls; the peripheral only changes it after seeing SCK low.
          cnt_d     = '0;
          sck_d     = 1'b0;
          rx_sr_d   = {rx_sr_q[WORD_BITS-2:0], CIPO};
          bit_cnt_d = bit_next;
          if (bit_next == BITS_ALL) begin
            state_d = ST_TAIL;
          end else begin
            tx_sr_d = {tx_sr_q[WORD_BITS-2:0], 1'b0};
            copi_d  = tx_sr_q[WORD_BITS-2];
            state_d = ST_LOW;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_LOW: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          sck_d   = 1'b1;
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_TAIL: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d      = '0;
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
          copi_d     = 1'b0;
`ifdef SPI_CONTROLLER_BURST_EN
          if (hold_q) begin
            tx_ready_d = 1'b1;
            state_d    = ST_WAIT;
          end else begin
            cs_d    = 1'b1;
            state_d = ST_GAP;
          end
`else
          cs_d    = 1'b1;
          state_d = ST_GAP;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (cnt_q == IDLE_LAST) begin
          cnt_d      = '0;
          tx_ready_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef SPI_CONTROLLER_BURST_EN
      ST_WAIT: begin
        // CS stays low; the next word skips SETUP and starts with a full LOW half-period.
        if (accept) begin
          tx_sr_d    = tx_data;
          copi_d     = tx_data[WORD_BITS-1];
          tx_ready_d = 1'b0;
          hold_d     = cs_hold;
          cnt_d      = '0;
          bit_cnt_d  = '0;
          state_d    = ST_LOW;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      sck_q      <= 1'b0;
      cs_q       <= 1'b1;
      copi_q     <= 1'b0;
`ifdef SPI_CONTROLLER_BURST_EN
      hold_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      copi_q     <= copi_d;
`ifdef SPI_CONTROLLER_BURST_EN
      hold_q     <= hold_d;
`endif
    end
  end

  assign tx_ready  = tx_ready_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = busy_q;
  assign SCK       = sck_q;
  assign CS        = cs_q;
  assign COPI      = copi_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_word_controller.sv
// Bench for spi_word_controller: expected words and timing are queued at accept and
// compared by a monitor against rx_valid and a behavioural SPI peripheral.
`timescale 1ns/1ps
module tb_spi_word_controller;
  localparam int W   = 64;
  localparam int D   = 4;
  localparam int SU  = 2;
  localparam int IDL = 2;
  localparam int TXN_CYC = 1 + SU + (2*W - 1)*D + D + IDL;
  localparam int LEAD_NORMAL = 1 + SU;
  localparam int LEAD_WAIT   = 1 + D;
  localparam logic [7:0] CMD_API_VERSION = 8'h01;

  logic         clk = 1'b0;
  logic         resetn;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         busy;
  logic         SCK;
  logic         CS;
  logic         COPI;
  logic         CIPO;
  logic [2:0]   dbg_state;
  logic         cs_hold;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] copi_exp_q[$];
  int           exp_cyc_q[$];

  bit           loopback = 1'b1;
  logic [W-1:0] periph_reply = '0;
  logic         periph_cipo = 1'b0;
  logic [W-1:0] cap = '0;
  logic [7:0]   last_cmd = '0;
  int           edges = 0;
  int           pidx = 0;
  int           cs_high_cnt = 0;
  int           win_edges_exp = W;
  bit           cs_prev = 1'b1;
  bit           sck_prev = 1'b0;
  bit           seen_window = 1'b0;
  bit           aborting = 1'b0;

  assign CIPO = loopback ? COPI : periph_cipo;

  spi_word_controller #(
    .WORD_BITS(W), .CLK_DIV(D), .CS_SETUP(SU), .CS_IDLE(IDL)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
`ifdef SPI_CONTROLLER_BURST_EN
    .cs_hold(cs_hold),
`endif
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .busy(busy),
    .SCK(SCK),
    .CS(CS),
    .COPI(COPI),
    .CIPO(CIPO),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor + peripheral model ----------------
  always @(negedge clk) begin
    bit sck_rise;
    bit sck_fall;
    sck_rise = SCK && !sck_prev;
    sck_fall = !SCK && sck_prev;

    if (rx_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_valid_unexpected: got pulse with rx_data %0h, expected no pulse", rx_data);
      end else begin
        check("rx_data", rx_data, exp_q.pop_front());
        check("rx_valid_cycle", W'(cyc), W'(exp_cyc_q.pop_front()));
      end
    end

    if (!CS && cs_prev) begin
      if (seen_window) begin
        checks++;
        if (cs_high_cnt < IDL + 1) begin
          errors++;
          $display("FAIL cs_high_gap: got %0d cycles, expected at least %0d", cs_high_cnt, IDL + 1);
        end
      end
      edges = 0;
      pidx  = 0;
    end

    if (!CS && sck_rise) begin
      edges++;
      cap = {cap[W-2:0], COPI};
      if (edges % W == 0) begin
        last_cmd = cap[W-1 -: 8];
        if (copi_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL copi_word_unexpected: got %0h, expected no word", cap);
        end else begin
          check("copi_word", cap, copi_exp_q.pop_front());
        end
      end
    end

    if (!CS && sck_fall) pidx++;

    if (CS && !cs_prev) begin
      if (!aborting) check("sck_rises_per_frame", W'(edges), W'(win_edges_exp));
      seen_window = 1'b1;
      edges = 0;
    end

    if (CS) pidx = 0;
    periph_cipo = (pidx < W) ? periph_reply[W-1-pidx] : 1'b0;
    cs_high_cnt = CS ? cs_high_cnt + 1 : 0;
    cs_prev  = CS;
    sck_prev = SCK;
  end

  // ---------------- driver tasks ----------------
  task automatic start(input logic [W-1:0] w, input logic [W-1:0] exp_rx, input bit push,
                       input bit hold, input int lead, input bit keep, output int acc);
    int guard;
    @(posedge clk); #1;
    tx_data  = w;
    tx_valid = 1'b1;
    cs_hold  = hold;
    guard = 0;
    acc = -1;
    while (acc < 0) begin
      @(negedge clk);
      if (tx_ready) acc = cyc;
      else if (++guard > 4*TXN_CYC) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no accept in %0d cycles, expected one", guard);
        acc = cyc;
      end
    end
    if (push) begin
      exp_q.push_back(exp_rx);
      exp_cyc_q.push_back(acc + lead + 2*W*D);
      copi_exp_q.push_back(w);
    end
    @(posedge clk); #1;
    if (!keep) tx_valid = 1'b0;
    @(negedge clk);
    check("busy_after_accept", W'(busy), W'(1'b1));
    check("cs_after_accept", W'(CS), W'(1'b0));
    check("tx_ready_after_accept", W'(tx_ready), W'(1'b0));
    check("copi_msb", W'(COPI), W'(w[W-1]));
  endtask

  task automatic wait_ready(input int acc, input int exp_len);
    int guard = 0;
    bit done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (tx_ready) done = 1'b1;
      else if (++guard > 4*TXN_CYC) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: got tx_ready low for %0d cycles, expected re-assert", guard);
        done = 1'b1;
      end
    end
    if (exp_len > 0) check("txn_length", W'(cyc - acc), W'(exp_len));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int acc1;
    int guard;
    logic [W-1:0] w;
    logic [W-1:0] e;

    resetn   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    cs_hold  = 1'b0;
    repeat (3) @(posedge clk);
    #3 resetn = 1'b1;
    @(negedge clk);
    check("rst_tx_ready", W'(tx_ready), W'(1'b1));
    check("rst_cs", W'(CS), W'(1'b1));
    check("rst_sck", W'(SCK), W'(1'b0));
    check("rst_copi", W'(COPI), W'(1'b0));
    check("rst_busy", W'(busy), W'(1'b0));
    check("rst_rx_valid", W'(rx_valid), W'(1'b0));
    check("rst_rx_data", rx_data, '0);

    // loopback of a directed word
    loopback = 1'b1;
    w = 64'hA5A5_0123_4567_89AB;
    start(w, w, 1'b1, 1'b0, LEAD_NORMAL, 1'b0, acc);
    wait_ready(acc, TXN_CYC);
    check("rx_data_held", rx_data, w);

    // version request answered by the peripheral model
    loopback = 1'b0;
    periph_reply = 64'h0000_0000_0001_0203;
    w = {CMD_API_VERSION, 56'h0};
    start(w, periph_reply, 1'b1, 1'b0, LEAD_NORMAL, 1'b0, acc);
    wait_ready(acc, TXN_CYC);
    check("header_decode", W'(last_cmd), W'(CMD_API_VERSION));

    // tx_valid held across two words
    loopback = 1'b1;
    start(64'h1, 64'h1, 1'b1, 1'b0, LEAD_NORMAL, 1'b1, acc1);
    start(64'h2, 64'h2, 1'b1, 1'b0, LEAD_NORMAL, 1'b0, acc);
    check("back_to_back_spacing", W'(acc - acc1), W'(TXN_CYC));
    wait_ready(acc, TXN_CYC);

    // tx_valid pulsed with other data while busy
    w = 64'hDEAD_BEEF_0BAD_F00D;
    start(w, w, 1'b1, 1'b0, LEAD_NORMAL, 1'b0, acc);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tx_valid = 1'b1;
      tx_data  = ~w;
      @(negedge clk);
      check("tx_ready_while_busy", W'(tx_ready), W'(1'b0));
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    wait_ready(acc, TXN_CYC);

    // reset in the middle of a transfer
    w = {$urandom, $urandom};
    start(w, w, 1'b0, 1'b0, LEAD_NORMAL, 1'b0, acc);
    guard = 0;
    while (edges < 30 && guard < 4*TXN_CYC) begin
      @(negedge clk);
      guard++;
    end
    #2;
    aborting = 1'b1;
    resetn = 1'b0;
    #1;
    check("abort_cs", W'(CS), W'(1'b1));
    check("abort_sck", W'(SCK), W'(1'b0));
    check("abort_busy", W'(busy), W'(1'b0));
    check("abort_tx_ready", W'(tx_ready), W'(1'b1));
    check("abort_rx_data", rx_data, '0);
    repeat (3) @(negedge clk);
    #2 resetn = 1'b1;
    repeat (2) @(negedge clk);
    aborting = 1'b0;
    check("abort_rx_data_after", rx_data, '0);
    w = 64'h0F1E_2D3C_4B5A_6978;
    start(w, w, 1'b1, 1'b0, LEAD_NORMAL, 1'b0, acc);
    wait_ready(acc, TXN_CYC);

    // randomized words against loopback or the peripheral model
    for (int i = 0; i < 6; i++) begin
      loopback = 1'($urandom_range(0, 1));
      w = {$urandom, $urandom};
      periph_reply = {$urandom, $urandom};
      e = loopback ? w : periph_reply;
      repeat ($urandom_range(0, 5)) @(posedge clk);
      start(w, e, 1'b1, 1'b0, LEAD_NORMAL, 1'b0, acc);
      wait_ready(acc, TXN_CYC);
    end

`ifdef SPI_CONTROLLER_BURST_EN
    // three-word burst under one CS window
    loopback = 1'b1;
    win_edges_exp = 3*W;
    w = {$urandom, $urandom};
    start(w, w, 1'b1, 1'b1, LEAD_NORMAL, 1'b0, acc);
    wait_ready(acc, 1 + SU + 2*W*D);
    check("burst_cs_in_wait", W'(CS), W'(1'b0));
    check("burst_busy_in_wait", W'(busy), W'(1'b1));
    w = {$urandom, $urandom};
    start(w, w, 1'b1, 1'b1, LEAD_WAIT, 1'b0, acc);
    wait_ready(acc, LEAD_WAIT + 2*W*D);
    w = {$urandom, $urandom};
    start(w, w, 1'b1, 1'b0, LEAD_WAIT, 1'b0, acc);
    wait_ready(acc, LEAD_WAIT + 2*W*D + IDL);
    check("burst_cs_after", W'(CS), W'(1'b1));
    win_edges_exp = W;
`endif

    repeat (5) @(negedge clk);
    check("rx_queue_drained", W'(exp_q.size()), '0);
    check("copi_queue_drained", W'(copi_exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
